// File: rtl/hid_pkg.sv
// Shared HID definitions: device types, lock keycodes, LED bit positions, LED FSM states.
// Build option HID_LED_COMPOSE_EN lets the Compose key (0x65) toggle lock bit 3.
package hid_pkg;

    typedef enum logic [1:0] {
        HID_NONE  = 2'd0,
        HID_KBD   = 2'd1,
        HID_MOUSE = 2'd2,
        HID_GAME  = 2'd3
    } hid_typ_e;

    localparam logic [7:0] KEY_NUM      = 8'h53;
    localparam logic [7:0] KEY_CAPS     = 8'h39;
    localparam logic [7:0] KEY_SCROLL   = 8'h47;
    localparam logic [7:0] KEY_COMPOSE  = 8'h65;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;

    localparam int LED_NUM     = 0;
    localparam int LED_CAPS    = 1;
    localparam int LED_SCROLL  = 2;
    localparam int LED_COMPOSE = 3;

    // Lock bits that keys are allowed to toggle; bit 3 stays at its initial value otherwise.
`ifdef HID_LED_COMPOSE_EN
    localparam logic [3:0] LOCK_MASK = 4'b1111;
`else
    localparam logic [3:0] LOCK_MASK = 4'b0111;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } led_state_e;

    function automatic logic key_hit(input logic [7:0] k1, input logic [7:0] k2,
                                     input logic [7:0] k3, input logic [7:0] k4,
                                     input logic [7:0] code);
        return (k1 == code) || (k2 == code) || (k3 == code) || (k4 == code);
    endfunction

endpackage

// File: rtl/hid_lock_led_ctrl_if.sv
// Report / LED-configuration bundle between the USB HID host core and the lock-LED controller.
interface hid_lock_led_ctrl_if;

    logic [1:0] typ;
    logic       report;
    logic       conerr;
    logic [7:0] key_modifiers;
    logic [7:0] key1;
    logic [7:0] key2;
    logic [7:0] key3;
    logic [7:0] key4;
    logic [3:0] leds;
    logic       update_leds_stb;
    logic [3:0] lock_leds;
    logic       pending;

    modport master (
        output typ, report, conerr, key_modifiers, key1, key2, key3, key4,
        input  leds, update_leds_stb, lock_leds, pending
    );

    modport slave (
        input  typ, report, conerr, key_modifiers, key1, key2, key3, key4,
        output leds, update_leds_stb, lock_leds, pending
    );

endinterface

// File: rtl/hid_key_match.sv
// Combinational keycode decoder: four report slots -> set of pressed lock keys plus rollover flag.
module hid_key_match
    import hid_pkg::*;
(
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    output logic [3:0] pressed,
    output logic       rollover
);

    // Any slot matching counts once, so duplicated keycodes collapse naturally.
    always_comb begin
        pressed              = '0;
        pressed[LED_NUM]     = key_hit(key1, key2, key3, key4, KEY_NUM);
        pressed[LED_CAPS]    = key_hit(key1, key2, key3, key4, KEY_CAPS);
        pressed[LED_SCROLL]  = key_hit(key1, key2, key3, key4, KEY_SCROLL);
        pressed[LED_COMPOSE] = key_hit(key1, key2, key3, key4, KEY_COMPOSE);
        pressed              = pressed & LOCK_MASK;
        rollover = (key1 == KEY_ROLLOVER) && (key2 == KEY_ROLLOVER) &&
                   (key3 == KEY_ROLLOVER) && (key4 == KEY_ROLLOVER);
    end

endmodule

// File: rtl/hid_lock_led_ctrl.sv
// Keyboard lock-LED controller: tracks Num/Caps/Scroll lock state and sends rate-limited LED updates.
// Compose support is selected by HID_LED_COMPOSE_EN (see hid_pkg).
module hid_lock_led_ctrl
    import hid_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 12000,
    parameter logic [3:0]  INIT_LEDS   = 4'b0001
) (
    input  logic                usbclk,
    input  logic                usbrst,
    hid_lock_led_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic             kbd_valid;
    logic             kbd_valid_q;
    logic             connect_evt;
    logic             disconnect_evt;
    logic             report_ok;
    logic             rollover;
    logic             go_issue;
    logic             stb;
    logic             pending_q;
    logic [3:0]       pressed;
    logic [3:0]       edges;
    logic [3:0]       prev_pressed;
    logic [3:0]       lock_q;
    logic [3:0]       leds_q;
    logic [CNT_W-1:0] hold_cnt;
    led_state_e       state_q;
    led_state_e       state_d;
    logic             unused_modifiers;

    hid_key_match u_key_match (
        .key1     (bus.key1),
        .key2     (bus.key2),
        .key3     (bus.key3),
        .key4     (bus.key4),
        .pressed  (pressed),
        .rollover (rollover)
    );

    assign unused_modifiers = ^bus.key_modifiers;

    assign kbd_valid      = (bus.typ == HID_KBD) && !bus.conerr;
    assign connect_evt    = kbd_valid && !kbd_valid_q;
    assign disconnect_evt = !kbd_valid && kbd_valid_q;
    assign report_ok      = bus.report && kbd_valid && !rollover;
    assign edges          = report_ok ? (pressed & ~prev_pressed) : 4'b0000;
    assign go_issue       = (state_q == ST_IDLE) && pending_q && kbd_valid;

    // Lock state and pending flag; a connect wins over a toggle, and a toggle re-arms pending
    // even on the edge where the current state is being captured for the host.
    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            kbd_valid_q  <= 1'b0;
            lock_q       <= INIT_LEDS;
            leds_q       <= INIT_LEDS;
            prev_pressed <= '0;
            pending_q    <= 1'b0;
        end else begin
            kbd_valid_q <= kbd_valid;
            if (go_issue) begin
                leds_q <= lock_q;
            end
            if (connect_evt) begin
                lock_q       <= INIT_LEDS;
                prev_pressed <= '0;
                pending_q    <= 1'b1;
            end else if (disconnect_evt) begin
                prev_pressed <= '0;
                pending_q    <= 1'b0;
            end else begin
                if (report_ok) begin
                    prev_pressed <= pressed;
                end
                if (|edges) begin
                    lock_q    <= lock_q ^ edges;
                    pending_q <= 1'b1;
                end else if (go_issue) begin
                    pending_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stb     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go_issue) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                stb     = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold-off counter: loaded as the strobe goes out, counts down and parks at zero.
    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            hold_cnt <= '0;
        end else if (state_q == ST_ISSUE) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state_q == ST_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign bus.leds            = leds_q;
    assign bus.update_leds_stb = stb;
    assign bus.lock_leds       = lock_q;
    assign bus.pending         = pending_q;

endmodule

// File: tb/tb_hid_lock_led_ctrl.sv
// Self-checking bench for hid_lock_led_ctrl: directed lock-key scenarios, then random reports
// compared every cycle against a timestamp-based reference model.
module tb_hid_lock_led_ctrl;

    localparam int         H    = 16;
    localparam logic [3:0] INIT = 4'b0001;
`ifdef HID_LED_COMPOSE_EN
    localparam logic COMPOSE = 1'b1;
`else
    localparam logic COMPOSE = 1'b0;
`endif

    logic usbclk = 1'b0;
    logic usbrst;

    hid_lock_led_ctrl_if bus();

    hid_lock_led_ctrl #(
        .HOLD_CYCLES (H),
        .INIT_LEDS   (INIT)
    ) dut (
        .usbclk (usbclk),
        .usbrst (usbrst),
        .bus    (bus)
    );

    always #5 usbclk = ~usbclk;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int last_stb = -1000;
    int stb_seen = 0;
    int snap;

    logic [1:0] cur_typ    = 2'd0;
    logic       cur_conerr = 1'b0;

    logic [3:0] m_lock    = INIT;
    logic [3:0] m_leds    = INIT;
    logic [3:0] m_prev    = 4'b0000;
    logic       m_pending = 1'b0;
    logic       m_valid_q = 1'b0;
    logic       m_stb     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, advances the reference model by one edge, then compares.
    task automatic applyStimulus(input logic rst, input logic rep,
                                 input logic [7:0] k1, input logic [7:0] k2,
                                 input logic [7:0] k3, input logic [7:0] k4);
        logic       valid;
        logic       go;
        logic       all_roll;
        logic [3:0] now_pressed;
        logic [7:0] keys [4];
        @(negedge usbclk);
        usbrst            = rst;
        bus.typ           = cur_typ;
        bus.conerr        = cur_conerr;
        bus.report        = rep;
        bus.key1          = k1;
        bus.key2          = k2;
        bus.key3          = k3;
        bus.key4          = k4;
        bus.key_modifiers = 8'($urandom);
        keys[0] = k1;
        keys[1] = k2;
        keys[2] = k3;
        keys[3] = k4;
        valid = (cur_typ == 2'd1) && !cur_conerr;
        if (rst) begin
            m_lock    = INIT;
            m_leds    = INIT;
            m_prev    = 4'b0000;
            m_pending = 1'b0;
            m_valid_q = 1'b0;
            m_stb     = 1'b0;
            last_stb  = -1000;
        end else begin
            go    = m_pending && valid && ((cyc - last_stb) >= H);
            m_stb = go;
            if (go) begin
                m_leds    = m_lock;
                m_pending = 1'b0;
                last_stb  = cyc + 1;
            end
            if (valid && !m_valid_q) begin
                m_lock    = INIT;
                m_prev    = 4'b0000;
                m_pending = 1'b1;
            end else if (!valid && m_valid_q) begin
                m_prev    = 4'b0000;
                m_pending = 1'b0;
            end else if (valid && rep) begin
                all_roll = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (keys[i] != 8'h01) all_roll = 1'b0;
                end
                if (!all_roll) begin
                    now_pressed = 4'b0000;
                    for (int i = 0; i < 4; i++) begin
                        case (keys[i])
                            8'h53:   now_pressed[0] = 1'b1;
                            8'h39:   now_pressed[1] = 1'b1;
                            8'h47:   now_pressed[2] = 1'b1;
                            8'h65:   now_pressed[3] = COMPOSE;
                            default: ;
                        endcase
                    end
                    for (int b = 0; b < 4; b++) begin
                        if (now_pressed[b] && !m_prev[b]) begin
                            m_lock[b] = ~m_lock[b];
                            m_pending = 1'b1;
                        end
                    end
                    m_prev = now_pressed;
                end
            end
            m_valid_q = valid;
        end
        @(posedge usbclk);
        #1;
        cyc++;
        checkOutput("leds", 32'(bus.leds), 32'(m_leds));
        checkOutput("stb", 32'(bus.update_leds_stb), 32'(m_stb));
        checkOutput("lock_leds", 32'(bus.lock_leds), 32'(m_lock));
        checkOutput("pending", 32'(bus.pending), 32'(m_pending));
        if (bus.update_leds_stb === 1'b1) stb_seen++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic pressKeys(input logic [7:0] k1, input logic [7:0] k2,
                             input logic [7:0] k3, input logic [7:0] k4);
        applyStimulus(1'b0, 1'b1, k1, k2, k3, k4);
    endtask

    function automatic logic [7:0] pickKey();
        case ($urandom_range(0, 7))
            0, 1:    return 8'h00;
            2:       return 8'h53;
            3:       return 8'h39;
            4:       return 8'h47;
            5:       return 8'h65;
            6:       return 8'h04;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic rst_r;
        logic rep_r;
        usbrst            = 1'b1;
        bus.typ           = 2'd0;
        bus.conerr        = 1'b0;
        bus.report        = 1'b0;
        bus.key_modifiers = 8'h00;
        bus.key1          = 8'h00;
        bus.key2          = 8'h00;
        bus.key3          = 8'h00;
        bus.key4          = 8'h00;

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("rst_leds", 32'(bus.leds), 32'(INIT));
        checkOutput("rst_pending", 32'(bus.pending), 32'd0);
        idleCycles(2);

        // Connect: one strobe right after the connect edge carrying INIT.
        cur_typ = 2'd1;
        idleCycles(1);
        idleCycles(1);
        checkOutput("conn_stb", 32'(bus.update_leds_stb), 32'd1);
        checkOutput("conn_leds", 32'(bus.leds), 32'(4'b0001));
        idleCycles(1);
        checkOutput("conn_pending_clr", 32'(bus.pending), 32'd0);
        idleCycles(20);

        // Caps on/off; second strobe waits for the hold window.
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        checkOutput("caps_on", 32'(bus.lock_leds), 32'(4'b0011));
        pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("caps_stb", 32'(bus.update_leds_stb), 32'd1);
        checkOutput("caps_leds", 32'(bus.leds), 32'(4'b0011));
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        checkOutput("caps_off", 32'(bus.lock_leds), 32'(4'b0001));
        snap = stb_seen;
        idleCycles(20);
        checkOutput("delayed_stb_count", 32'(stb_seen - snap), 32'd1);
        checkOutput("delayed_leds", 32'(bus.leds), 32'(4'b0001));
        idleCycles(20);

        // Reconnect opens a window; three Caps toggles inside it coalesce into one strobe.
        cur_typ = 2'd0;
        idleCycles(1);
        cur_typ = 2'd1;
        idleCycles(2);
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        snap = stb_seen;
        idleCycles(20);
        checkOutput("coalesce_count", 32'(stb_seen - snap), 32'd1);
        checkOutput("coalesce_leds", 32'(bus.leds), 32'(4'b0011));
        idleCycles(5);

        // Back to Num-only, then Num+Scroll together with a duplicate Num.
        pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        idleCycles(20);
        pressKeys(8'h53, 8'h47, 8'h53, 8'h00);
        checkOutput("num_scroll", 32'(bus.lock_leds), 32'(4'b0100));
        pressKeys(8'h53, 8'h47, 8'h53, 8'h00);
        checkOutput("held_keys", 32'(bus.lock_leds), 32'(4'b0100));
        idleCycles(20);

        // Rollover between Caps press and a repeat of the held key changes nothing.
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        idleCycles(20);
        snap = stb_seen;
        pressKeys(8'h01, 8'h01, 8'h01, 8'h01);
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        checkOutput("rollover_lock", 32'(bus.lock_leds), 32'(4'b0110));
        idleCycles(20);
        checkOutput("rollover_stb_count", 32'(stb_seen - snap), 32'd0);

        // Mouse reports are ignored.
        cur_typ = 2'd2;
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        pressKeys(8'h39, 8'h53, 8'h00, 8'h00);
        checkOutput("mouse_lock", 32'(bus.lock_leds), 32'(4'b0110));
        checkOutput("mouse_pending", 32'(bus.pending), 32'd0);

        // Reset in the middle of a hold window.
        cur_typ = 2'd1;
        idleCycles(2);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("midhold_rst_leds", 32'(bus.leds), 32'(INIT));
        checkOutput("midhold_rst_lock", 32'(bus.lock_leds), 32'(INIT));
        checkOutput("midhold_rst_stb", 32'(bus.update_leds_stb), 32'd0);
        checkOutput("midhold_rst_pending", 32'(bus.pending), 32'd0);
        idleCycles(5);

        // Connection error mid-hold blocks strobes until the keyboard is valid again.
        pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
        cur_conerr = 1'b1;
        idleCycles(1);
        checkOutput("conerr_pending", 32'(bus.pending), 32'd0);
        snap = stb_seen;
        for (int i = 0; i < 15; i++) begin
            pressKeys(8'h39, 8'h00, 8'h00, 8'h00);
            pressKeys(8'h00, 8'h00, 8'h00, 8'h00);
        end
        checkOutput("conerr_stb_count", 32'(stb_seen - snap), 32'd0);
        checkOutput("conerr_lock", 32'(bus.lock_leds), 32'(4'b0011));
        cur_conerr = 1'b0;
        snap = stb_seen;
        idleCycles(20);
        checkOutput("reconnect_stb_count", 32'(stb_seen - snap), 32'd1);

        // Random reports, device changes, errors and resets against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0)
                cur_typ = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            if (cur_conerr) begin
                if ($urandom_range(0, 39) == 0) cur_conerr = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                cur_conerr = 1'b1;
            end
            rst_r = ($urandom_range(0, 999) == 0);
            rep_r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                applyStimulus(rst_r, rep_r, 8'h01, 8'h01, 8'h01, 8'h01);
            else
                applyStimulus(rst_r, rep_r, pickKey(), pickKey(), pickKey(), pickKey());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hid_lock_led_ctrl.md
# hid_lock_led_ctrl

Keyboard lock-LED controller for the USB HID host core. It watches decoded keyboard reports for NumLock, CapsLock and ScrollLock presses and keeps the lock state. When that state changes, or a keyboard (re)connects, it drives the host's `leds` / `update_leds_stb` configuration inputs. Rate limiting stops the host being flooded with SET_REPORT requests. It sits beside `usb_hid_host` in the `usbclk` domain; its `lock_leds` output also feeds board LEDs.

## Interface
- `HOLD_CYCLES`, default 12000: minimum number of `usbclk` cycles from one `update_leds_stb` pulse to the next (1 ms at 12 MHz). Must be ≥ 2.
- `INIT_LEDS`, default 4'b0001: lock state loaded at reset and at every keyboard (re)connect. Bit0 Num, bit1 Caps, bit2 Scroll, bit3 Compose.
- `usbclk`  in  1  clock, 12 MHz USB clock.
- `usbrst`  in  1  reset; one clock; reset is synchronous and active-high.
- `typ`  in  2  device type from host: 0 none, 1 keyboard, 2 mouse, 3 gamepad.
- `report`  in  1  one-cycle strobe; a new report is valid on the key inputs.
- `conerr`  in  1  connection error from host (level).
- `key_modifiers`  in  8  modifier byte (ignored except for pass-through sampling).
- `key1`..`key4`  in  8 each  pressed keycodes; 0x00 = empty slot.
- `leds`  out  4  LED bits presented to the host; stable whenever `update_leds_stb` = 1 and during hold-off.
- `update_leds_stb`  out  1  one-cycle request to the host to send `leds`.
- `lock_leds`  out  4  live lock state, for board LEDs.
- `pending`  out  1  change waiting to be sent.

## Operation
- **Keyboard valid:** `typ` == 1 and `conerr` == 0.
- **Report qualification:** a report is processed only when `report` = 1 and the keyboard is valid.
  - Ignore a rollover report (all four keys == 0x01) completely. Keep the previous pressed set.
- **Pressed set:** 3 bits (4 with the compose option), formed by matching any of `key1`..`key4` against 0x53 Num, 0x39 Caps, 0x47 Scroll.
  - Duplicated keycodes count once.
  - The pressed set is registered as `prev_pressed`.
- **Toggle rule:** rising edge (pressed now, not in `prev_pressed`) XOR-toggles the matching `lock_leds` bit. Held keys do nothing. Several edges in one report toggle all of them together.
- **Pending:** set by any toggle or by a connect event. Cleared when a strobe is issued.
  - Multiple changes during hold-off coalesce into one later strobe that carries the latest state.
- **Connect event:** keyboard-valid rises.
  - `lock_leds` ← `INIT_LEDS`, `prev_pressed` ← 0, pending ← 1.
- **Disconnect:** keyboard-valid falls.
  - `prev_pressed` ← 0, pending ← 0, `lock_leds` holds.
  - FSM returns to IDLE after any hold-off in progress finishes.
- **FSM:**
  - IDLE: pending and keyboard valid → ISSUE.
  - ISSUE: `update_leds_stb` = 1 for this cycle only; `leds` ← `lock_leds` (captured on entry); pending cleared; counter ← `HOLD_CYCLES`-1 → HOLD.
  - HOLD: counter decrements; when it reaches 0 → IDLE.
- **Simultaneous events:**
  - A toggle in the same cycle as ISSUE sets pending again. The next strobe follows after HOLD.
  - A connect event takes priority over a toggle in the same cycle.
- **Counter:** width is $clog2(`HOLD_CYCLES`). It does not wrap; it saturates at 0.

## Timing
- **Reset values:**
  - `leds` = `INIT_LEDS`, `lock_leds` = `INIT_LEDS`
  - `update_leds_stb` = 0, `pending` = 0
  - FSM in IDLE, counter = 0, `prev_pressed` = 0
- **Reset mid-HOLD** aborts immediately; no strobe is issued.
- **Report latency:** report sampled at edge N → `lock_leds` / `pending` updated after edge N → strobe high in cycle N+1 (after edge N+1) if IDLE.
- **Strobe spacing:** consecutive strobes are at least `HOLD_CYCLES`+1 cycles apart.
- **Stability:** `leds` changes only in ISSUE.

## Configuration
- `HID_LED_COMPOSE_EN` defined:
  - keycode 0x65 (Application/Compose) joins the pressed set and toggles `lock_leds[3]`.
- Not defined:
  - bit 3 of `leds` / `lock_leds` is forced to `INIT_LEDS[3]` and never toggles;
  - 0x65 is ignored.

## Structure
- **Shared package `hid_pkg`:**
  - `typ` encodings (`HID_NONE`, `HID_KBD`, `HID_MOUSE`, `HID_GAME`);
  - lock keycodes and the rollover code 0x01;
  - LED bit indices;
  - FSM state enum.
- **Sub-module `hid_key_match`:** combinational; 4 keycodes → pressed-set vector plus rollover flag. Reused later by other key decoders.
- **Top of block:** lock/pending registers, FSM, hold counter.

## Test plan
- Reset, then connect (`typ` = 1): one strobe 1 cycle after the connect edge with `leds` = 0001; `pending` = 0 afterwards.
- Report key1 = 0x39, then a report with keys empty, then key1 = 0x39 again: `lock_leds` 0001→0011→0001. Two strobes, second delayed until HOLD expires (`HOLD_CYCLES` = 16 in the bench).
- Three Caps toggles inside one hold window: exactly one further strobe after the window, carrying the final state 0011.
- Report key1 = 0x53, key2 = 0x47, key3 = 0x53: Num and Scroll toggle together → 0100. Repeating the same report (held keys) causes no change.
- Rollover report (all 0x01) between Caps-pressed and Caps-released: no toggle, no strobe. `typ` = 2 report with 0x39: ignored.
- Assert `usbrst` during HOLD and set `conerr` = 1 mid-hold: outputs return to reset values. With `conerr` high, no strobes are issued until the keyboard is valid again.
